// File: rtl/lfsr_bank_if.sv
// Bundle of the lfsr_bank configuration inputs and random outputs.
// The master drives the seed, the controls and the threshold; the slave is the LFSR bank.
interface lfsr_bank_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int PW    = 8
);
    logic [WIDTH-1:0]     seed;
    logic                 reseed;
    logic                 en;
    logic [PW-1:0]        prob;
    logic [NCH*WIDTH-1:0] dataOut;
    logic [NCH-1:0]       sample;
    logic                 valid;

    modport master (
        output seed, reseed, en, prob,
        input  dataOut, sample, valid
    );

    modport slave (
        input  seed, reseed, en, prob,
        output dataOut, sample, valid
    );
endinterface

// File: rtl/lfsr_bank.sv
// NCH Fibonacci LFSR channels seeded from one shared seed, with leap-forward,
// a warm-up discard phase, synchronous reseed and a per-channel Bernoulli sampler.
//
// state | meaning
// WARM  | discarding WARMUP advances; outputs not yet valid
// RUN   | channels advance on en; outputs valid
module lfsr_bank #(
    parameter int               WIDTH  = 16,
    parameter int               NCH    = 4,
    parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
    parameter int               STEP   = 1,
    parameter int               WARMUP = 0,
    parameter int               PW     = 8
) (
    input  logic        clk,
    input  logic        reset,
    lfsr_bank_if.slave  bus
);

    localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    typedef enum logic {WARM, RUN} state_t;

    state_t           state, nextState;
    logic [CW-1:0]    cnt, nextCnt;
    logic             validReg, nextValid;
    logic             doLoad, doAdvance;
    logic [WIDTH-1:0] chan [NCH];

    // The (r == 0) term pulls the register out of the all-zero lock-up state.
    function automatic logic [WIDTH-1:0] shiftOnce(input logic [WIDTH-1:0] r);
        logic fb;
        fb = (^(r & TAPS)) ^ (r == '0);
        return {r[WIDTH-2:0], fb};
    endfunction

    function automatic logic [WIDTH-1:0] leap(input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] t;
        t = r;
        for (int i = 0; i < STEP; i++) begin
            t = shiftOnce(t);
        end
        return t;
    endfunction

    function automatic logic [WIDTH-1:0] chanSeed(input logic [WIDTH-1:0] s, input int c);
        logic [WIDTH-1:0] rot;
        int k;
        k = c % WIDTH;
        for (int i = 0; i < WIDTH; i++) begin
            rot[i] = s[(i - k + WIDTH) % WIDTH];
        end
        return rot ^ WIDTH'(c);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= (WARMUP > 0) ? WARM : RUN;
            cnt      <= CW'(WARMUP);
            validReg <= 1'b0;
        end else begin
            state    <= nextState;
            cnt      <= nextCnt;
            validReg <= nextValid;
        end
    end

    // Reseed outranks both en and the end of warm-up.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        nextValid = validReg;
        doLoad    = 1'b0;
        doAdvance = 1'b0;
        if (bus.reseed) begin
            doLoad  = 1'b1;
            nextCnt = CW'(WARMUP);
            if (WARMUP > 0) begin
                nextState = WARM;
                nextValid = 1'b0;
            end else begin
                nextState = RUN;
                nextValid = 1'b1;
            end
        end else begin
            case (state)
                WARM: begin
                    doAdvance = 1'b1;
                    nextValid = 1'b0;
                    if (cnt <= CW'(1)) begin
                        nextCnt   = '0;
                        nextState = RUN;
                        nextValid = 1'b1;
                    end else begin
                        nextCnt = cnt - CW'(1);
                    end
                end
                RUN: begin
                    doAdvance = bus.en;
                    nextValid = 1'b1;
                end
                default: begin
                    nextState = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                chan[c] <= chanSeed(bus.seed, c);
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (doLoad) begin
                    chan[c] <= chanSeed(bus.seed, c);
                end else if (doAdvance) begin
                    chan[c] <= leap(chan[c]);
                end
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_out
        assign bus.dataOut[c*WIDTH +: WIDTH] = chan[c];
        assign bus.sample[c] = validReg & (chan[c][WIDTH-1 -: PW] < bus.prob);
    end

    assign bus.valid = validReg;

endmodule

// File: tb/tb_lfsr_bank.sv
// Directed bench for lfsr_bank: four configurations share one clock and reset;
// expectations are queued with a due cycle and a monitor compares them at the falling edge.
module tb_lfsr_bank;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lfsr_bank_if #(.WIDTH(16), .NCH(2), .PW(4)) ifA ();
    lfsr_bank_if #(.WIDTH(16), .NCH(2), .PW(8)) ifB ();
    lfsr_bank_if #(.WIDTH(4),  .NCH(1), .PW(4)) ifC ();
    lfsr_bank_if #(.WIDTH(16), .NCH(2), .PW(8)) ifD ();

    lfsr_bank #(.WIDTH(16), .NCH(2), .TAPS(16'hB400), .STEP(1), .WARMUP(0), .PW(4))
        dutA (.clk(clk), .reset(reset), .bus(ifA));
    lfsr_bank #(.WIDTH(16), .NCH(2), .TAPS(16'hB400), .STEP(2), .WARMUP(0), .PW(8))
        dutB (.clk(clk), .reset(reset), .bus(ifB));
    lfsr_bank #(.WIDTH(4), .NCH(1), .TAPS(4'hC), .STEP(1), .WARMUP(0), .PW(4))
        dutC (.clk(clk), .reset(reset), .bus(ifC));
    lfsr_bank #(.WIDTH(16), .NCH(2), .TAPS(16'hB400), .STEP(1), .WARMUP(4), .PW(8))
        dutD (.clk(clk), .reset(reset), .bus(ifD));

    localparam int A_DATA = 0, A_VALID = 1, A_SAMPLE = 2, B_DATA = 3,
                   C_DATA = 4, D_DATA = 5, D_VALID = 6, D_SAMPLE = 7;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];

    // x^4+x^3+1 from seed 1: full 15-state cycle back to 1, never 0.
    logic [3:0] cSeq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                              4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            A_DATA:   return ifA.dataOut;
            A_VALID:  return 32'(ifA.valid);
            A_SAMPLE: return 32'(ifA.sample);
            B_DATA:   return ifB.dataOut;
            C_DATA:   return 32'(ifC.dataOut);
            D_DATA:   return ifD.dataOut;
            D_VALID:  return 32'(ifD.valid);
            D_SAMPLE: return 32'(ifD.sample);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expectAt(input int sel, input int dly, input logic [31:0] exp, input string name);
        exp_t e;
        e.due  = cyc + dly;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                act = actual(sbq[i].sel);
                nChecks++;
                if (act !== sbq[i].exp) begin
                    nFail++;
                    $display("FAIL %s @cyc %0d: got %h, expected %h", sbq[i].name, cyc, act, sbq[i].exp);
                end
                sbq.delete(i);
            end else if (sbq[i].due < cyc) begin
                nChecks++;
                nFail++;
                $display("FAIL %s: check slot cyc %0d missed (now %0d)", sbq[i].name, sbq[i].due, cyc);
                sbq.delete(i);
            end
        end
    end

    initial begin
        reset = 1'b1;
        ifA.seed = 16'h0001; ifA.reseed = 0; ifA.en = 0; ifA.prob = '0;
        ifB.seed = 16'h0001; ifB.reseed = 0; ifB.en = 0; ifB.prob = '0;
        ifC.seed = 4'h1;     ifC.reseed = 0; ifC.en = 0; ifC.prob = '0;
        ifD.seed = 16'h0001; ifD.reseed = 0; ifD.en = 0; ifD.prob = '0;
        tick(); tick();

        expectAt(A_DATA,  0, 32'h0003_0001, "a_reset_data");
        expectAt(A_VALID, 0, 32'h0,         "a_reset_valid");
        expectAt(C_DATA,  0, 32'h1,         "c_reset_data");
        expectAt(D_DATA,  0, 32'h0003_0001, "d_reset_data");
        expectAt(D_VALID, 0, 32'h0,         "d_reset_valid");
        tick();

        reset = 1'b0;
        ifA.en = 1'b1;
        ifC.en = 1'b1;
        ifD.prob = 8'hFF;
        expectAt(A_DATA,  1, 32'h0006_0002, "a_first_adv");
        expectAt(A_VALID, 1, 32'h1,         "a_valid_first_edge");
        expectAt(D_VALID, 1, 32'h0,         "d_warm_valid1");
        expectAt(D_SAMPLE,1, 32'h0,         "d_warm_sample");
        expectAt(D_VALID, 2, 32'h0,         "d_warm_valid2");
        expectAt(D_VALID, 3, 32'h0,         "d_warm_valid3");
        expectAt(D_VALID, 4, 32'h1,         "d_warm_done_valid");
        expectAt(D_DATA,  4, 32'h0030_0010, "d_warm_done_data");
        expectAt(D_SAMPLE,4, 32'h3,         "d_warm_done_sample");
        for (int i = 0; i < 15; i++) begin
            expectAt(C_DATA, i + 1, 32'(cSeq[i]), $sformatf("c_period_%0d", i + 1));
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 0) ifA.en = 1'b0;
        end
        ifC.en = 1'b0;

        // Leap-forward: STEP=2 after 5 advances must match STEP=1 after 10.
        ifA.seed = 16'h0001; ifA.reseed = 1'b1;
        ifB.seed = 16'h0001; ifB.reseed = 1'b1;
        tick();
        ifA.reseed = 1'b0; ifB.reseed = 1'b0;
        ifA.en = 1'b1;     ifB.en = 1'b1;
        expectAt(A_DATA,  0,  32'h0003_0001, "a_reseed_load");
        expectAt(A_VALID, 0,  32'h1,         "a_reseed_valid");
        expectAt(B_DATA,  5,  32'h0C01_0400, "b_step2_x5");
        expectAt(A_DATA,  10, 32'h0C01_0400, "a_step1_x10");
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 4) ifB.en = 1'b0;
        end
        ifA.en = 1'b0;

        // Reseed with en in RUN on the warm-up bank: load only, then restart warm-up.
        ifD.seed = 16'h0005; ifD.reseed = 1'b1; ifD.en = 1'b1;
        tick();
        ifD.reseed = 1'b0;
        expectAt(D_DATA,   0, 32'h000B_0005, "d_reseed_load");
        expectAt(D_VALID,  0, 32'h0,         "d_reseed_valid0");
        expectAt(D_SAMPLE, 0, 32'h0,         "d_reseed_sample0");
        expectAt(D_VALID,  3, 32'h0,         "d_reseed_valid_late");
        expectAt(D_VALID,  4, 32'h1,         "d_reseed_valid1");
        expectAt(D_DATA,   4, 32'h00B0_0050, "d_reseed_warm_data");
        repeat (4) tick();
        ifD.en = 1'b0;

        // Sampler thresholds on ch0=E000, ch1=C000, reseed beating en.
        ifA.seed = 16'hE000; ifA.reseed = 1'b1; ifA.en = 1'b1;
        tick();
        ifA.reseed = 1'b0; ifA.en = 1'b0; ifA.prob = 4'h0;
        expectAt(A_DATA,   0, 32'hC000_E000, "a_reseed_over_en");
        expectAt(A_SAMPLE, 0, 32'h0,         "a_sample_p0");
        tick();
        ifA.prob = 4'hF;
        expectAt(A_SAMPLE, 0, 32'h3,         "a_sample_pF");
        tick();
        ifA.prob = 4'hE;
        expectAt(A_SAMPLE, 0, 32'h2,         "a_sample_pE");
        tick();

        // Zero seed must escape the all-zero state.
        ifA.seed = 16'h0000;
        reset = 1'b1;
        expectAt(A_DATA,  0, 32'h0001_0000, "a_zero_seed_reset");
        expectAt(A_VALID, 0, 32'h0,         "a_zero_seed_valid0");
        tick();
        reset = 1'b0;
        ifA.en = 1'b1;
        expectAt(A_DATA,  1, 32'h0002_0001, "a_zero_escape");
        expectAt(A_VALID, 1, 32'h1,         "a_zero_valid1");
        tick();
        ifA.en = 1'b0;

        for (int i = 0; i < 50 && sbq.size() != 0; i++) tick();
        if (sbq.size() != 0) begin
            $display("FAIL drain: %0d expectations still queued", sbq.size());
            $fatal(1, "scoreboard did not drain");
        end
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/lfsr_bank.md
Name: lfsr_bank

Overview:
- Multi-channel, parametrised successor to the single-LFSR random source.
- NCH independent Fibonacci LFSRs of configurable width and tap mask, each with its own seed derived from one shared seed.
- Optional leap-forward of STEP shifts per clock, a warm-up discard phase, synchronous reseed, and a per-channel Bernoulli sampler.
- Feeds the RBM stochastic neuron units: `sample` gives one Bernoulli bit per channel against a supplied probability.

Parameters:
- WIDTH, 16, bits per LFSR channel (>=3).
- NCH, 4, number of channels.
- TAPS, 16'hB400, feedback mask; bit i set means reg[i] enters the XOR (default x^16+x^14+x^13+x^11).
- STEP, 1, LFSR shifts per enabled clock (1..WIDTH-1).
- WARMUP, 0, enabled-independent shifts discarded after reset/reseed before valid (0..255).
- PW, 8, probability width for the sampler (1..WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- seed  in  WIDTH  shared seed, sampled on reset and on reseed.
- reseed  in  1  synchronous reload request, one-cycle pulse.
- en  in  1  advance all channels by STEP shifts this cycle (RUN state only).
- prob  in  PW  Bernoulli threshold, common to all channels.
- dataOut  out  NCH*WIDTH  channel c at [c*WIDTH +: WIDTH], registered.
- sample  out  NCH  per-channel Bernoulli bit.
- valid  out  1  registered; high when outputs are post-warm-up.

Behaviour:
- Channel seed: seed_c = rotl(seed, c mod WIDTH) XOR c, with c zero-extended to WIDTH.
- Single shift f(r): r' = {r[WIDTH-2:0], fb}, where fb = (XOR-reduce of r & TAPS) XOR (r == 0).
  - The zero term forces escape from the all-zero state.
- Leap: one advance applies f STEP times combinationally within a single cycle.
  - dataOut with STEP=k after n advances equals STEP=1 after n*k advances.
- States: WARM, RUN. Warm-up counter is ceil(log2(WARMUP+1)) bits wide.
- reset asserted (async):
  - every channel register = seed_c; valid = 0.
  - If WARMUP>0: state = WARM, counter = WARMUP. Otherwise: state = RUN, valid = 1 on the first clock edge after reset deasserts.
- WARM:
  - every clock advances all channels once (STEP shifts) regardless of en; counter decrements.
  - At the edge where counter reaches 0: state -> RUN, valid -> 1 (registered with that edge).
- RUN:
  - en = 1: advance all channels.
  - en = 0: hold.
  - valid stays 1.
- reseed = 1 at an edge (any state):
  - channels load seed_c; the counter reloads WARMUP.
  - state -> WARM with valid -> 0 if WARMUP>0.
  - state -> RUN with valid = 1 if WARMUP=0.
  - reseed has priority over en and over warm-up completion in the same cycle.
- sample[c] = valid AND (dataOut_c[WIDTH-1 -: PW] < prob), unsigned compare, combinational from registers.
  - prob = 0 gives sample = 0 always.
  - Expected P(sample=1) is approximately prob / 2^PW.
- Simultaneous en and reseed: reseed wins, no advance.
- Reset mid-warm-up: full restart as above.
- dataOut is visible during WARM, but consumers must gate on valid.

Test Plan:
- WIDTH=16, NCH=2, STEP=1, WARMUP=0, seed=16'h0001, reset then en=1 for 1 cycle -> ch0 0001->0002, ch1 0003->0006, valid=1.
- seed=16'h0000 reset, en=1 one cycle -> ch0 0000->0001 (zero escape), ch1 0001->0002.
- WIDTH=4, TAPS=4'hC, seed=1, en held -> ch0 returns to 4'h1 after exactly 15 advances, never reaches 0.
- STEP=2 vs STEP=1 benches, same seed -> STEP=2 dataOut after 5 advances equals STEP=1 after 10.
- WARMUP=4, seed=1, en=0 -> valid=0 for 4 edges after reset release, then 1; ch0 = 16'h0010; sample=0 while valid=0.
- RUN, PW=4, prob=4'h0 -> sample=0; prob=4'hF with ch0=16'hE000 -> sample[0]=1.
- RUN, pulse reseed with en=1, WARMUP=4 -> ch0 = seed_0 (no advance), valid=0 next edge, returns to 1 after 4 edges.
